// File: rtl/tor_ram_sched.sv
// Shares a 3-read/1-write RAM between two round-robin write requesters and a
// sliding-window scan engine that reads mem[i], mem[i+1], mem[i+2] each cycle.
module tor_ram_sched #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_valid,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_data,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_data,
    output logic          b_ready,
    input  logic          scan_start,
    input  logic [AW-1:0] scan_base,
    input  logic [AW:0]   scan_len,
    output logic          scan_busy,
    output logic          scan_done,
    output logic          win_valid,
    output logic [AW-1:0] win_idx,
    output logic [DW-1:0] win_d0,
    output logic [DW-1:0] win_d1,
    output logic [DW-1:0] win_d2,
    output logic          ram_ce,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr0,
    output logic [AW-1:0] ram_addr1,
    output logic [AW-1:0] ram_addr2,
    output logic [DW-1:0] ram_data_w,
    input  logic [DW-1:0] ram_data_r0,
    input  logic [DW-1:0] ram_data_r1,
    input  logic [DW-1:0] ram_data_r2
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

    state_t        state, state_nx;
    logic          prio_b;
    logic [AW-1:0] cur_addr;
    logic [AW:0]   cnt;
    logic          done_q;
    logic          win_valid_q;
    logic [AW-1:0] win_idx_q;
    logic          grant_a, grant_b, issue;

    always_comb begin
        state_nx   = state;
        grant_a    = 1'b0;
        grant_b    = 1'b0;
        issue      = 1'b0;
        ram_ce     = 1'b0;
        ram_we     = 1'b0;
        ram_addr0  = '0;
        ram_addr1  = '0;
        ram_addr2  = '0;
        ram_data_w = '0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        if (scan_len != '0)
                            state_nx = SCAN;
                    end else if (a_valid && (!b_valid || !prio_b)) begin
                        grant_a = 1'b1;
                    end else if (b_valid) begin
                        grant_b = 1'b1;
                    end
                end
                SCAN: begin
                    issue = 1'b1;
                    if (cnt == (AW+1)'(1))
                        state_nx = DRAIN;
                end
                DRAIN:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
        // Only one of grant_a, grant_b, issue can be set in any cycle.
        if (grant_a) begin
            ram_ce     = 1'b1;
            ram_we     = 1'b1;
            ram_addr0  = a_addr;
            ram_data_w = a_data;
        end
        if (grant_b) begin
            ram_ce     = 1'b1;
            ram_we     = 1'b1;
            ram_addr0  = b_addr;
            ram_data_w = b_data;
        end
        if (issue) begin
            ram_ce    = 1'b1;
            ram_addr0 = cur_addr;
            ram_addr1 = cur_addr + AW'(1);
            ram_addr2 = cur_addr + AW'(2);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio_b      <= 1'b0;
            cur_addr    <= '0;
            cnt         <= '0;
            done_q      <= 1'b0;
            win_valid_q <= 1'b0;
            win_idx_q   <= '0;
        end else begin
            state       <= state_nx;
            done_q      <= 1'b0;
            win_valid_q <= issue;
            if (issue) begin
                win_idx_q <= cur_addr;
                cur_addr  <= cur_addr + AW'(1);
                cnt       <= cnt - (AW+1)'(1);
                if (cnt == (AW+1)'(1))
                    done_q <= 1'b1;
            end
            if (state == IDLE && scan_start) begin
                cur_addr <= scan_base;
                cnt      <= (scan_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : scan_len;
                if (scan_len == '0)
                    done_q <= 1'b1;
            end
            if (grant_a)
                prio_b <= 1'b1;
            if (grant_b)
                prio_b <= 1'b0;
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign scan_busy = (state != IDLE);
    assign scan_done = done_q;
    assign win_valid = win_valid_q;
    assign win_idx   = win_idx_q;
    // Read data is only forwarded while a window is valid so idle outputs stay 0.
    assign win_d0    = win_valid_q ? ram_data_r0 : '0;
    assign win_d1    = win_valid_q ? ram_data_r1 : '0;
    assign win_d2    = win_valid_q ? ram_data_r2 : '0;

endmodule

// File: tb/tb_tor_ram_sched.sv
// Directed bench for tor_ram_sched with a behavioural registered-address RAM.
module tb_tor_ram_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_valid, b_valid, a_ready, b_ready;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_data, b_data;
    logic       scan_start, scan_busy, scan_done, win_valid;
    logic [3:0] scan_base, win_idx;
    logic [4:0] scan_len;
    logic [7:0] win_d0, win_d1, win_d2;
    logic       ram_ce, ram_we;
    logic [3:0] ram_addr0, ram_addr1, ram_addr2;
    logic [7:0] ram_data_w, ram_data_r0, ram_data_r1, ram_data_r2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [16];
    logic [3:0] rq0, rq1, rq2;

    always #5 clk = ~clk;

    tor_ram_sched #(.AW(4), .DW(8), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
        .scan_start(scan_start), .scan_base(scan_base), .scan_len(scan_len),
        .scan_busy(scan_busy), .scan_done(scan_done),
        .win_valid(win_valid), .win_idx(win_idx),
        .win_d0(win_d0), .win_d1(win_d1), .win_d2(win_d2),
        .ram_ce(ram_ce), .ram_we(ram_we),
        .ram_addr0(ram_addr0), .ram_addr1(ram_addr1), .ram_addr2(ram_addr2),
        .ram_data_w(ram_data_w),
        .ram_data_r0(ram_data_r0), .ram_data_r1(ram_data_r1), .ram_data_r2(ram_data_r2)
    );

    // RAM model: addresses registered on ce, combinational read, 1-clk write.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;
        rq0 = 4'd0; rq1 = 4'd0; rq2 = 4'd0;
    end

    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr0] <= ram_data_w;
            rq0 <= ram_addr0;
            rq1 <= ram_addr1;
            rq2 <= ram_addr2;
        end
    end

    assign ram_data_r0 = mem[rq0];
    assign ram_data_r1 = mem[rq1];
    assign ram_data_r2 = mem[rq2];

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_a(input logic [3:0] addr, input logic [7:0] data);
        @(negedge clk);
        a_valid = 1'b1;
        a_addr  = addr;
        a_data  = data;
        #1;
        check_output("fill_ready", a_ready, 1);
    endtask

    // Assumes mem[i] == i, so every window triple is (i, i+1, i+2) mod 16.
    task automatic run_scan(input logic [3:0] base, input logic [4:0] len);
        logic [3:0] iss, idx;
        @(negedge clk);
        scan_start = 1'b1;
        scan_base  = base;
        scan_len   = len;
        #1;
        check_output("start_ce", ram_ce, 0);
        check_output("start_busy", scan_busy, 0);
        for (int c = 1; c <= int'(len) + 2; c++) begin
            @(negedge clk);
            scan_start = 1'b0;
            #1;
            iss = base + 4'(c - 1);
            idx = base + 4'(c - 2);
            check_output("busy", scan_busy, (len != 0 && c <= int'(len) + 1) ? 1 : 0);
            check_output("ce", ram_ce, (c <= int'(len)) ? 1 : 0);
            check_output("done", scan_done, (c == int'(len) + 1) ? 1 : 0);
            check_output("win_valid", win_valid, (c >= 2 && c <= int'(len) + 1) ? 1 : 0);
            if (c <= int'(len)) begin
                check_output("we", ram_we, 0);
                check_output("addr0", ram_addr0, iss);
                check_output("addr1", ram_addr1, 4'(iss + 4'd1));
                check_output("addr2", ram_addr2, 4'(iss + 4'd2));
            end
            if (c >= 2 && c <= int'(len) + 1) begin
                check_output("win_idx", win_idx, idx);
                check_output("win_d0", win_d0, idx);
                check_output("win_d1", win_d1, 4'(idx + 4'd1));
                check_output("win_d2", win_d2, 4'(idx + 4'd2));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b0;
        a_addr = 4'd3; a_data = 8'h5A; b_addr = 4'd0; b_data = 8'h00;
        scan_start = 1'b0; scan_base = 4'd0; scan_len = 5'd0;

        // Reset: requests must be blocked and outputs idle
        @(negedge clk);
        #1;
        check_output("rst_a_ready", a_ready, 0);
        check_output("rst_ce", ram_ce, 0);
        @(negedge clk);
        a_valid = 1'b0;
        rst_n   = 1'b1;
        #1;
        check_output("rst_busy", scan_busy, 0);
        check_output("rst_win_valid", win_valid, 0);
        check_output("rst_done", scan_done, 0);
        check_output("rst_win_idx", win_idx, 0);

        // Test 1 write: A writes 0x5A to address 3 in the same cycle
        @(negedge clk);
        a_valid = 1'b1; a_addr = 4'd3; a_data = 8'h5A;
        #1;
        check_output("t1_a_ready", a_ready, 1);
        check_output("t1_b_ready", b_ready, 0);
        check_output("t1_ce", ram_ce, 1);
        check_output("t1_we", ram_we, 1);
        check_output("t1_addr0", ram_addr0, 3);
        check_output("t1_data_w", ram_data_w, 8'h5A);
        @(negedge clk);
        a_valid = 1'b0;

        // Test 2: fresh reset, both requesters compete, grants alternate A,B,A,B
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h11;
            b_valid = 1'b1; b_addr = 4'd2; b_data = 8'h22;
            #1;
            check_output("t2_a_ready", a_ready, (c % 2 == 0) ? 1 : 0);
            check_output("t2_b_ready", b_ready, (c % 2 == 1) ? 1 : 0);
            check_output("t2_addr0", ram_addr0, (c % 2 == 0) ? 1 : 2);
            check_output("t2_data_w", ram_data_w, (c % 2 == 0) ? 8'h11 : 8'h22);
        end
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0;

        // Test 1 scan: base 3, len 1 returns the earlier write
        @(negedge clk);
        scan_start = 1'b1; scan_base = 4'd3; scan_len = 5'd1;
        @(negedge clk);
        scan_start = 1'b0;
        #1;
        check_output("t1s_ce", ram_ce, 1);
        check_output("t1s_addr0", ram_addr0, 3);
        @(negedge clk);
        #1;
        check_output("t1s_win_valid", win_valid, 1);
        check_output("t1s_win_d0", win_d0, 8'h5A);
        check_output("t1s_done", scan_done, 1);

        // Test 3: mem[i] = i, then a wrapping scan at base 14
        for (int i = 0; i < 16; i++) write_a(4'(i), 8'(i));
        @(negedge clk);
        a_valid = 1'b0;
        run_scan(4'd14, 5'd3);

        // Test 5: zero-length and full-length scans
        run_scan(4'd7, 5'd0);
        run_scan(4'd5, 5'd16);

        // Test 4: scan beats a same-cycle write; write lands after DRAIN
        @(negedge clk);
        a_valid = 1'b1; a_addr = 4'd9; a_data = 8'h09;
        scan_start = 1'b1; scan_base = 4'd0; scan_len = 5'd2;
        #1;
        check_output("t4_start_a_ready", a_ready, 0);
        check_output("t4_start_we", ram_we, 0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            scan_start = 1'b0;
            #1;
            check_output("t4_busy_a_ready", a_ready, 0);
            check_output("t4_busy", scan_busy, 1);
        end
        @(negedge clk);
        #1;
        check_output("t4_idle_a_ready", a_ready, 1);
        check_output("t4_idle_busy", scan_busy, 0);
        check_output("t4_idle_addr0", ram_addr0, 9);
        @(negedge clk);
        a_valid = 1'b0;

        // Test 6: reset during the second window of a len=8 scan
        @(negedge clk);
        scan_start = 1'b1; scan_base = 4'd2; scan_len = 5'd8;
        @(negedge clk);
        scan_start = 1'b0;
        @(negedge clk);
        #1;
        check_output("t6_win1_idx", win_idx, 2);
        @(negedge clk);
        #1;
        check_output("t6_win2_valid", win_valid, 1);
        check_output("t6_win2_idx", win_idx, 3);
        rst_n = 1'b0;
        #1;
        check_output("t6_rst_ce", ram_ce, 0);
        check_output("t6_rst_addr0", ram_addr0, 0);
        check_output("t6_rst_addr1", ram_addr1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_output("t6_busy", scan_busy, 0);
        check_output("t6_win_valid", win_valid, 0);
        check_output("t6_done", scan_done, 0);
        check_output("t6_win_idx", win_idx, 0);
        check_output("t6_win_d0", win_d0, 0);
        check_output("t6_ce", ram_ce, 0);
        @(negedge clk);
        #1;
        check_output("t6_done_later", scan_done, 0);
        check_output("t6_busy_later", scan_busy, 0);
        run_scan(4'd10, 5'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
